// File: rtl/rssi_agc_ctrl_if.sv
// rssi_agc_ctrl_if
//   Run-control and result bundle between the link layer / IQ-to-dB block
//   and the RSSI AGC sequencer.
//   master : drives i_start, i_abort, i_db_q8; observes the results
//   slave  : the sequencer (rssi_agc_ctrl)
//   Signals:
//     i_start       single-cycle run request
//     i_abort       cancel the current run
//     i_db_q8       signed Q8.8 dB sample from the IQ-to-dB block
//     o_meas_en     enable to the IQ-to-dB block
//     o_gain_idx    front-end gain index
//     o_gain_update one-cycle strobe when o_gain_idx changes
//     o_rssi_q8     signed Q8.8 averaged RSSI of the last completed window
//     o_rssi_valid  one-cycle strobe when o_rssi_q8 is updated
//     o_busy        sequencer not idle
//     o_locked      last run ended in band
interface rssi_agc_ctrl_if #(
  parameter int GAIN_W = 3
) ();
  logic                i_start;
  logic                i_abort;
  logic signed [15:0]  i_db_q8;
  logic                o_meas_en;
  logic [GAIN_W-1:0]   o_gain_idx;
  logic                o_gain_update;
  logic signed [15:0]  o_rssi_q8;
  logic                o_rssi_valid;
  logic                o_busy;
  logic                o_locked;

  modport master (
    output i_start, i_abort, i_db_q8,
    input  o_meas_en, o_gain_idx, o_gain_update, o_rssi_q8,
           o_rssi_valid, o_busy, o_locked
  );

  modport slave (
    input  i_start, i_abort, i_db_q8,
    output o_meas_en, o_gain_idx, o_gain_update, o_rssi_q8,
           o_rssi_valid, o_busy, o_locked
  );
endinterface

// File: rtl/rssi_agc_ctrl.sv
// rssi_agc_ctrl
//   Sequencer for the IQ-to-dB power path of the BLE receive chain. Enables
//   the dB block, discards samples while its smoother settles, averages a
//   window of dB results, and steps the front-end gain index until the
//   average lands in the target band or the iteration limit is reached.
//   Ports:
//     i_clk   system clock
//     i_rst   synchronous active-high reset
//     agc_if  rssi_agc_ctrl_if.slave (run control, dB input, gain/RSSI outputs)
//   Optional build macro: AGC_COARSE_STEP_EN
//     When defined, an average at least 4*HYST_Q8 away from target moves the
//     gain by 2 (saturating at 0 / max); otherwise only single steps are made.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_IDLE   | waiting for i_start; dB block disabled
//   S_SETTLE | dB block enabled, samples discarded for SETTLE_CYCLES
//   S_ACCUM  | summing 2^AVG_LOG2 dB samples
//   S_DECIDE | publish average, pick step / lock / give up
//   S_APPLY  | new gain applied, wait GAIN_SETTLE_CYCLES before re-settling
module rssi_agc_ctrl #(
  parameter int SETTLE_CYCLES      = 16,
  parameter int AVG_LOG2           = 3,
  parameter int TARGET_Q8          = -5120,
  parameter int HYST_Q8            = 768,
  parameter int GAIN_W             = 3,
  parameter int GAIN_RESET         = 4,
  parameter int GAIN_SETTLE_CYCLES = 8,
  parameter int MAX_ITER           = 6
) (
  input  logic            i_clk,
  input  logic            i_rst,
  rssi_agc_ctrl_if.slave  agc_if
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_ACCUM  = 3'd2,
    S_DECIDE = 3'd3,
    S_APPLY  = 3'd4
  } state_t;

  localparam int ACC_W   = 16 + AVG_LOG2;
  localparam int AVG_LEN = 1 << AVG_LOG2;
  localparam int CNT_MAX = (SETTLE_CYCLES > AVG_LEN) ?
                           ((SETTLE_CYCLES > GAIN_SETTLE_CYCLES) ? SETTLE_CYCLES : GAIN_SETTLE_CYCLES) :
                           ((AVG_LEN > GAIN_SETTLE_CYCLES) ? AVG_LEN : GAIN_SETTLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int ITER_W  = $clog2(MAX_ITER + 2);
  localparam int BAND_HI = TARGET_Q8 + HYST_Q8;
  localparam int BAND_LO = TARGET_Q8 - HYST_Q8;

  localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  ACCUM_LD  = CNT_W'(AVG_LEN - 1);
  localparam logic [CNT_W-1:0]  APPLY_LD  = CNT_W'(GAIN_SETTLE_CYCLES - 1);
  localparam logic [ITER_W-1:0] ITER_LIM  = ITER_W'(MAX_ITER);
  localparam logic [GAIN_W-1:0] GAIN_MAX  = '1;
  localparam logic [GAIN_W-1:0] GAIN_INIT = GAIN_W'(GAIN_RESET);
  localparam logic [GAIN_W-1:0] GAIN_ONE  = GAIN_W'(1);
  localparam logic [GAIN_W-1:0] GAIN_TWO  = GAIN_W'(2);

  state_t                    r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
  logic signed [ACC_W-1:0]   r_acc, w_acc_nxt;
  logic [ITER_W-1:0]         r_iter, w_iter_nxt;
  logic [GAIN_W-1:0]         r_gain, w_gain_nxt;
  logic signed [15:0]        r_rssi, w_rssi_nxt;
  logic                      r_rssi_valid, w_rssi_valid_nxt;
  logic                      r_gain_update, w_gain_update_nxt;
  logic                      r_locked, w_locked_nxt;
  logic                      r_meas_en;
  logic                      r_busy;

  logic signed [ACC_W-1:0]   w_db_ext;
  logic signed [ACC_W-1:0]   w_acc_sum;
  logic signed [ACC_W-1:0]   w_avg_full;
  logic signed [15:0]        w_avg;
  logic signed [31:0]        w_avg32;
  logic                      w_need_dec;
  logic                      w_need_inc;
  logic                      w_coarse;
  logic [GAIN_W-1:0]         w_gain_dn;
  logic [GAIN_W-1:0]         w_gain_up;

  // Window sum is 16+AVG_LOG2 bits wide so 2^AVG_LOG2 full-scale samples fit.
  assign w_db_ext   = $signed({{AVG_LOG2{agc_if.i_db_q8[15]}}, agc_if.i_db_q8});
  assign w_acc_sum  = r_acc + w_db_ext;
  assign w_avg_full = r_acc >>> AVG_LOG2;  // floor toward -inf
  assign w_avg      = w_avg_full[15:0];
  assign w_avg32    = {{16{w_avg[15]}}, w_avg};
  assign w_need_dec = (w_avg32 > BAND_HI);
  assign w_need_inc = (w_avg32 < BAND_LO);

`ifdef AGC_COARSE_STEP_EN
  logic signed [31:0] w_err;
  logic signed [31:0] w_err_abs;
  assign w_err     = w_avg32 - TARGET_Q8;
  assign w_err_abs = (w_err < 0) ? -w_err : w_err;
  assign w_coarse  = (w_err_abs >= 4 * HYST_Q8);
`else
  assign w_coarse  = 1'b0;
`endif

  // A coarse step near the rail degrades to a single step rather than wrapping.
  assign w_gain_dn = (w_coarse && (r_gain >= GAIN_TWO)) ? r_gain - GAIN_TWO : r_gain - GAIN_ONE;
  assign w_gain_up = (w_coarse && (r_gain <= GAIN_MAX - GAIN_TWO)) ? r_gain + GAIN_TWO : r_gain + GAIN_ONE;

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_acc_nxt         = r_acc;
    w_iter_nxt        = r_iter;
    w_gain_nxt        = r_gain;
    w_rssi_nxt        = r_rssi;
    w_rssi_valid_nxt  = 1'b0;
    w_gain_update_nxt = 1'b0;
    w_locked_nxt      = r_locked;

    case (r_state)
      S_IDLE: begin
        if (agc_if.i_start && !agc_if.i_abort) begin
          w_state_nxt  = S_SETTLE;
          w_cnt_nxt    = SETTLE_LD;
          w_iter_nxt   = '0;
          w_locked_nxt = 1'b0;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_ACCUM;
          w_cnt_nxt   = ACCUM_LD;
          w_acc_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_ACCUM: begin
        w_acc_nxt = w_acc_sum;
        if (r_cnt == '0) begin
          w_state_nxt = S_DECIDE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_DECIDE: begin
        w_rssi_nxt       = w_avg;
        w_rssi_valid_nxt = 1'b1;
        w_state_nxt      = S_IDLE;
        if (w_need_dec) begin
          if ((r_gain != '0) && (r_iter != ITER_LIM)) begin
            w_gain_nxt        = w_gain_dn;
            w_gain_update_nxt = 1'b1;
            w_iter_nxt        = r_iter + ITER_W'(1);
            w_state_nxt       = S_APPLY;
            w_cnt_nxt         = APPLY_LD;
          end else begin
            w_locked_nxt = 1'b0;
          end
        end else if (w_need_inc) begin
          if ((r_gain != GAIN_MAX) && (r_iter != ITER_LIM)) begin
            w_gain_nxt        = w_gain_up;
            w_gain_update_nxt = 1'b1;
            w_iter_nxt        = r_iter + ITER_W'(1);
            w_state_nxt       = S_APPLY;
            w_cnt_nxt         = APPLY_LD;
          end else begin
            w_locked_nxt = 1'b0;
          end
        end else begin
          w_locked_nxt = 1'b1;
        end
      end
      S_APPLY: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = SETTLE_LD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides whatever the state decided this cycle, including DECIDE.
    if (agc_if.i_abort && (r_state != S_IDLE)) begin
      w_state_nxt       = S_IDLE;
      w_rssi_nxt        = r_rssi;
      w_rssi_valid_nxt  = 1'b0;
      w_gain_nxt        = r_gain;
      w_gain_update_nxt = 1'b0;
      w_locked_nxt      = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_acc         <= '0;
      r_iter        <= '0;
      r_gain        <= GAIN_INIT;
      r_rssi        <= '0;
      r_rssi_valid  <= 1'b0;
      r_gain_update <= 1'b0;
      r_locked      <= 1'b0;
      r_meas_en     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_acc         <= w_acc_nxt;
      r_iter        <= w_iter_nxt;
      r_gain        <= w_gain_nxt;
      r_rssi        <= w_rssi_nxt;
      r_rssi_valid  <= w_rssi_valid_nxt;
      r_gain_update <= w_gain_update_nxt;
      r_locked      <= w_locked_nxt;
      // Enable and busy follow the state being entered so they are registered
      // yet line up with the state itself.
      r_meas_en     <= (w_state_nxt != S_IDLE);
      r_busy        <= (w_state_nxt != S_IDLE);
    end
  end

  assign agc_if.o_meas_en     = r_meas_en;
  assign agc_if.o_gain_idx    = r_gain;
  assign agc_if.o_gain_update = r_gain_update;
  assign agc_if.o_rssi_q8     = r_rssi;
  assign agc_if.o_rssi_valid  = r_rssi_valid;
  assign agc_if.o_busy        = r_busy;
  assign agc_if.o_locked      = r_locked;

endmodule

// File: tb/tb_rssi_agc_ctrl.sv
// tb_rssi_agc_ctrl
//   Directed bench for rssi_agc_ctrl. Instance A uses default parameters,
//   instance B uses GAIN_RESET=7, MAX_ITER=2. Both share the dB input and
//   abort; each has its own start.
`timescale 1ns/1ps
module tb_rssi_agc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               start_a, start_b, abort;
  logic signed [15:0] dbv0, dbv1;
  logic               alt_en;
  logic               alt_ph = 1'b0;

  rssi_agc_ctrl_if #(.GAIN_W(3)) ifa ();
  rssi_agc_ctrl_if #(.GAIN_W(3)) ifb ();

  assign ifa.i_start = start_a;
  assign ifa.i_abort = abort;
  assign ifa.i_db_q8 = (alt_en && alt_ph) ? dbv1 : dbv0;
  assign ifb.i_start = start_b;
  assign ifb.i_abort = abort;
  assign ifb.i_db_q8 = (alt_en && alt_ph) ? dbv1 : dbv0;

  rssi_agc_ctrl dut_a (
    .i_clk  (clk),
    .i_rst  (rst),
    .agc_if (ifa.slave)
  );

  rssi_agc_ctrl #(
    .GAIN_RESET (7),
    .MAX_ITER   (2)
  ) dut_b (
    .i_clk  (clk),
    .i_rst  (rst),
    .agc_if (ifb.slave)
  );

  always @(negedge clk) alt_ph <= ~alt_ph;

  int nva = 0, nua = 0, nvb = 0, nub = 0;
  always @(negedge clk) begin
    if (ifa.o_rssi_valid)  nva++;
    if (ifa.o_gain_update) nua++;
    if (ifb.o_rssi_valid)  nvb++;
    if (ifb.o_gain_update) nub++;
  end

`ifdef AGC_COARSE_STEP_EN
  localparam int G_DN_BIG = 2;
  localparam int G_UP_BIG = 6;
`else
  localparam int G_DN_BIG = 3;
  localparam int G_UP_BIG = 5;
`endif

  typedef struct {
    int d0;
    int d1;
    int rssi;
    int gain;
    int upd;
    int lock;
  } vec_t;

  localparam int NV = 10;
  vec_t tv [NV];

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    abort   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Returns 1ns after the edge that samples the start request.
  task automatic go(input bit b);
    if (b) start_b = 1'b1;
    else   start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_valid(input bit b, input int lim, output int cyc);
    cyc = -1;
    for (int i = 1; i <= lim; i++) begin
      tick();
      if (b ? ifb.o_rssi_valid : ifa.o_rssi_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input bit b, input int lim, output int cyc);
    cyc = -1;
    for (int i = 1; i <= lim; i++) begin
      tick();
      if (!(b ? ifb.o_busy : ifa.o_busy)) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    int v0, u0;

    tv[0] = '{d0: -5120,  d1: -5120,  rssi: -5120,  gain: 4,        upd: 0, lock: 1};
    tv[1] = '{d0: -5000,  d1: -5001,  rssi: -5001,  gain: 4,        upd: 0, lock: 1};
    tv[2] = '{d0: -2560,  d1: -2560,  rssi: -2560,  gain: 3,        upd: 1, lock: 0};
    tv[3] = '{d0: -4352,  d1: -4352,  rssi: -4352,  gain: 4,        upd: 0, lock: 1};
    tv[4] = '{d0: -4351,  d1: -4351,  rssi: -4351,  gain: 3,        upd: 1, lock: 0};
    tv[5] = '{d0: -5888,  d1: -5888,  rssi: -5888,  gain: 4,        upd: 0, lock: 1};
    tv[6] = '{d0: -5889,  d1: -5889,  rssi: -5889,  gain: 5,        upd: 1, lock: 0};
    tv[7] = '{d0: 1024,   d1: 1024,   rssi: 1024,   gain: G_DN_BIG, upd: 1, lock: 0};
    tv[8] = '{d0: -32768, d1: -32768, rssi: -32768, gain: G_UP_BIG, upd: 1, lock: 0};
    tv[9] = '{d0: 32767,  d1: 32767,  rssi: 32767,  gain: G_DN_BIG, upd: 1, lock: 0};

    dbv0   = '0;
    dbv1   = '0;
    alt_en = 1'b0;

    // Reset state
    do_reset();
    chk("rst_gain_a",  int'(ifa.o_gain_idx), 4);
    chk("rst_gain_b",  int'(ifb.o_gain_idx), 7);
    chk("rst_rssi",    int'(ifa.o_rssi_q8), 0);
    chk("rst_busy",    int'(ifa.o_busy), 0);
    chk("rst_meas_en", int'(ifa.o_meas_en), 0);
    chk("rst_locked",  int'(ifa.o_locked), 0);
    chk("rst_valid",   int'(ifa.o_rssi_valid), 0);
    chk("rst_update",  int'(ifa.o_gain_update), 0);

    // Single-decision vectors from reset
    for (int k = 0; k < NV; k++) begin
      do_reset();
      dbv0   = 16'(tv[k].d0);
      dbv1   = 16'(tv[k].d1);
      alt_en = (tv[k].d0 != tv[k].d1);
      go(1'b0);
      chk($sformatf("v%0d_meas_en", k), int'(ifa.o_meas_en), 1);
      wait_valid(1'b0, 40, cyc);
      chk($sformatf("v%0d_latency", k), cyc, 25);
      chk($sformatf("v%0d_rssi", k), int'(ifa.o_rssi_q8), tv[k].rssi);
      chk($sformatf("v%0d_gain", k), int'(ifa.o_gain_idx), tv[k].gain);
      chk($sformatf("v%0d_update", k), int'(ifa.o_gain_update), tv[k].upd);
      if (tv[k].upd == 0) begin
        tick();
        chk($sformatf("v%0d_busy", k), int'(ifa.o_busy), 0);
        chk($sformatf("v%0d_locked", k), int'(ifa.o_locked), tv[k].lock);
      end else begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk($sformatf("v%0d_abort_busy", k), int'(ifa.o_busy), 0);
        chk($sformatf("v%0d_abort_locked", k), int'(ifa.o_locked), 0);
        chk($sformatf("v%0d_abort_gain", k), int'(ifa.o_gain_idx), tv[k].gain);
      end
    end
    alt_en = 1'b0;

    // One step down, then relock on the second window
    do_reset();
    dbv0 = -16'sd2560;
    u0 = nua;
    go(1'b0);
    wait_valid(1'b0, 40, cyc);
    chk("relock_first_lat", cyc, 25);
    chk("relock_first_gain", int'(ifa.o_gain_idx), 3);
    dbv0 = -16'sd5120;
    wait_valid(1'b0, 60, cyc);
    chk("relock_second_lat", cyc, 33);
    chk("relock_rssi", int'(ifa.o_rssi_q8), -5120);
    tick();
    chk("relock_locked", int'(ifa.o_locked), 1);
    chk("relock_gain", int'(ifa.o_gain_idx), 3);
    chk("relock_busy", int'(ifa.o_busy), 0);
    chk("relock_updates", nua - u0, 1);

    // Never in band: walk gain down to 0 and exit on saturation
    do_reset();
    dbv0 = -16'sd2560;
    v0 = nva;
    u0 = nua;
    go(1'b0);
    wait_idle(1'b0, 400, cyc);
    chk("sat_lo_done_cycle", cyc, 25 + 4 * 33);
    tick();
    chk("sat_lo_updates", nua - u0, 4);
    chk("sat_lo_valids", nva - v0, 5);
    chk("sat_lo_gain", int'(ifa.o_gain_idx), 0);
    chk("sat_lo_locked", int'(ifa.o_locked), 0);

    // Gain 7, level far below band: increment impossible
    do_reset();
    dbv0 = -16'sd12800;
    v0 = nvb;
    u0 = nub;
    go(1'b1);
    wait_idle(1'b1, 100, cyc);
    chk("sat_hi_done_cycle", cyc, 25);
    tick();
    chk("sat_hi_valids", nvb - v0, 1);
    chk("sat_hi_updates", nub - u0, 0);
    chk("sat_hi_gain", int'(ifb.o_gain_idx), 7);
    chk("sat_hi_locked", int'(ifb.o_locked), 0);
    chk("sat_hi_rssi", int'(ifb.o_rssi_q8), -12800);

    // Iteration limit (MAX_ITER=2) from gain 7
    do_reset();
    dbv0 = -16'sd2560;
    v0 = nvb;
    u0 = nub;
    go(1'b1);
    wait_idle(1'b1, 200, cyc);
    chk("iter_done_cycle", cyc, 25 + 2 * 33);
    tick();
    chk("iter_updates", nub - u0, 2);
    chk("iter_valids", nvb - v0, 3);
    chk("iter_gain", int'(ifb.o_gain_idx), 5);
    chk("iter_locked", int'(ifb.o_locked), 0);

    // Abort sampled at cycle 20
    do_reset();
    dbv0 = -16'sd2560;
    v0 = nva;
    u0 = nua;
    go(1'b0);
    repeat (19) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("abort_meas_en", int'(ifa.o_meas_en), 0);
    chk("abort_busy", int'(ifa.o_busy), 0);
    repeat (40) tick();
    chk("abort_valids", nva - v0, 0);
    chk("abort_updates", nua - u0, 0);
    chk("abort_gain", int'(ifa.o_gain_idx), 4);
    chk("abort_locked", int'(ifa.o_locked), 0);

    // Start and abort together in IDLE
    do_reset();
    dbv0 = -16'sd5120;
    v0 = nva;
    start_a = 1'b1;
    abort   = 1'b1;
    tick();
    start_a = 1'b0;
    abort   = 1'b0;
    chk("start_abort_busy", int'(ifa.o_busy), 0);
    chk("start_abort_meas_en", int'(ifa.o_meas_en), 0);
    repeat (30) tick();
    chk("start_abort_valids", nva - v0, 0);

    // Reset in the middle of a run after a gain step
    do_reset();
    dbv0 = -16'sd2560;
    go(1'b0);
    wait_valid(1'b0, 40, cyc);
    chk("midrst_pre_gain", int'(ifa.o_gain_idx), 3);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_gain", int'(ifa.o_gain_idx), 4);
    chk("midrst_busy", int'(ifa.o_busy), 0);
    chk("midrst_meas_en", int'(ifa.o_meas_en), 0);
    chk("midrst_rssi", int'(ifa.o_rssi_q8), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
